// File: rtl/uart_rx_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_ctrl_if
//  Description : Link between the UART receive controller and the receiver
//                datapath (enable, oversample tick, parity setup, byte
//                hand-off).
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_ctrl_if;
    logic       rx_en;
    logic       rx_data_sample;
    logic       no_parity;
    logic       ev_parity;
    logic       rd_data_flag;
    logic       rx_ok;
    logic [7:0] rxd_out;
    logic       parity_error;

    // Controller side
    modport master (
        output rx_en, rx_data_sample, no_parity, ev_parity, rd_data_flag,
        input  rx_ok, rxd_out, parity_error
    );

    // Receiver datapath side
    modport slave (
        input  rx_en, rx_data_sample, no_parity, ev_parity, rd_data_flag,
        output rx_ok, rxd_out, parity_error
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_ctrl
//  Description : UART receive controller. Shadows the line configuration,
//                generates the oversample tick, captures each received byte
//                into a show-ahead FIFO and raises a host interrupt.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_ctrl #(
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_W      = 16
) (
    input  wire logic                          clk,
    input  wire logic                          rst_n,
    input  wire logic                          cfg_en,
    input  wire logic [DIV_W-1:0]              cfg_div,
    input  wire logic                          cfg_no_parity,
    input  wire logic                          cfg_ev_parity,
    uart_rx_ctrl_if.master                     rxif,
    input  wire logic                          pop,
    output logic [7:0]                         rdata,
    output logic                               rdata_perr,
    output logic                               empty,
    output logic                               full,
    output logic [$clog2(FIFO_DEPTH):0]        count,
    output logic                               overrun,
    input  wire logic                          ovr_clr,
    output logic                               irq
);

    localparam int c_aw = $clog2(FIFO_DEPTH);
    localparam int c_cw = c_aw + 1;
    localparam logic [c_cw-1:0] c_depth = c_cw'(FIFO_DEPTH);

    // Configuration shadow and enable pipeline
    logic [DIV_W-1:0] r_div;
    logic             r_no_parity;
    logic             r_ev_parity;
    logic             r_rx_en;
    logic [DIV_W-1:0] r_tick_cnt;
    logic             r_rx_ok_prev;

    // FIFO state
    logic [8:0]       r_mem [FIFO_DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_cw-1:0]  r_count;
    logic             r_overrun;
    logic             r_irq;

    logic             w_empty;
    logic             w_full;
    logic             w_push;
    logic             w_rd;
    logic             w_wr;
    logic             w_drop;

    // Shadow follows the host config only while disabled so a live frame never sees it change
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_div       <= '0;
            r_no_parity <= 1'b1;
            r_ev_parity <= 1'b0;
        end else if (!cfg_en) begin
            r_div       <= cfg_div;
            r_no_parity <= cfg_no_parity;
            r_ev_parity <= cfg_ev_parity;
        end
    end

    // Receiver enable is the host enable delayed by one cycle; rx_ok history for edge detect
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rx_en      <= 1'b0;
            r_rx_ok_prev <= 1'b0;
        end else begin
            r_rx_en      <= cfg_en;
            r_rx_ok_prev <= rxif.rx_ok;
        end
    end

    // Oversample divider: counts 0..div, wraps after the terminal count
    always_ff @(posedge clk) begin
        if (!rst_n || !r_rx_en) begin
            r_tick_cnt <= '0;
        end else if (r_tick_cnt >= r_div) begin
            // >= also recovers if the shadow shrinks during the disable cycle
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + DIV_W'(1);
        end
    end

    assign rxif.rx_en          = r_rx_en;
    assign rxif.rx_data_sample = r_rx_en && (r_tick_cnt == r_div);
    assign rxif.no_parity      = r_no_parity;
    assign rxif.ev_parity      = r_ev_parity;
    assign rxif.rd_data_flag   = rxif.rx_ok & r_rx_en;

    // One push per frame: the rising edge of rx_ok while enabled
    assign w_push  = rxif.rx_ok & ~r_rx_ok_prev & r_rx_en;
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_depth);
    // A pop on an empty FIFO is ignored; a pop frees room for a same-cycle push when full
    assign w_rd    = pop & ~w_empty;
    assign w_wr    = w_push & (~w_full | w_rd);
    assign w_drop  = w_push & w_full & ~w_rd;

    // Storage array, write side only (not reset: contents are gated by count)
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= {rxif.parity_error, rxif.rxd_out};
        end
    end

    // Pointers and occupancy; pointers wrap naturally since depth is a power of two
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + c_aw'(1);
            if (w_rd) r_rd_ptr <= r_rd_ptr + c_aw'(1);
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + c_cw'(1);
                2'b01:   r_count <= r_count - c_cw'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky overrun; a drop in the same cycle as a clear keeps it set
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_overrun <= 1'b0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
        end else if (ovr_clr) begin
            r_overrun <= 1'b0;
        end
    end

    // Interrupt reflects the previous cycle's FIFO/overrun state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= ~w_empty | r_overrun;
        end
    end

    assign rdata      = w_empty ? 8'hFF : r_mem[r_rd_ptr][7:0];
    assign rdata_perr = w_empty ? 1'b0  : r_mem[r_rd_ptr][8];
    assign empty      = w_empty;
    assign full       = w_full;
    assign count      = r_count;
    assign overrun    = r_overrun;
    assign irq        = r_irq;

endmodule
`default_nettype wire

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: number of received-byte entries; power of two, 2..16.
REQ-002 Parameter DIV_W, default 16: width of the baud divisor.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 cfg_en  input  1  receiver enable from host.
REQ-006 cfg_div  input  DIV_W  oversample divisor; one sample tick every cfg_div+1 clk cycles.
REQ-007 cfg_no_parity  input  1  1 = frame has no parity bit.
REQ-008 cfg_ev_parity  input  1  1 = even parity, 0 = odd parity; ignored when cfg_no_parity=1.
REQ-009 rx_en  output  1  enable to the receiver datapath.
REQ-010 rx_data_sample  output  1  16x oversample tick to the receiver datapath, one clk wide.
REQ-011 no_parity, ev_parity  output  1 each  frozen parity configuration to the receiver datapath.
REQ-012 rd_data_flag  output  1  data-gate to the receiver datapath.
REQ-013 rx_ok  input  1  receiver in stop state (level, high for several ticks).
REQ-014 rxd_out  input  8  received byte, valid while rd_data_flag=1 and rx_ok=1.
REQ-015 parity_error  input  1  parity status, valid while rx_ok=1.
REQ-016 pop  input  1  host removes the head entry.
REQ-017 rdata  output  8  head entry byte.
REQ-018 rdata_perr  output  1  head entry parity-error flag.
REQ-019 empty, full  output  1 each  FIFO status.
REQ-020 count  output  $clog2(FIFO_DEPTH)+1  number of stored entries.
REQ-021 overrun  output  1  sticky: a byte was dropped.
REQ-022 ovr_clr  input  1  clears overrun.
REQ-023 irq  output  1  host interrupt.

Function
REQ-024 Config shadow (div, no_parity, ev_parity) SHALL load every cycle while cfg_en=0 and SHALL hold while cfg_en=1; no_parity/ev_parity outputs come from the shadow.
REQ-025 rx_en SHALL be cfg_en registered: one clk latency on both edges.
REQ-026 Tick counter SHALL count 0..shadow div while rx_en=1; rx_data_sample=1 in the cycle the counter equals shadow div, and the counter wraps to 0 in the next cycle.
REQ-027 shadow div=0 SHALL yield rx_data_sample=1 in every cycle while rx_en=1.
REQ-028 While rx_en=0 the tick counter SHALL be held at 0 and rx_data_sample SHALL be 0.
REQ-029 rd_data_flag SHALL equal rx_ok & rx_en (combinational).
REQ-030 A capture SHALL occur in the single cycle where rx_ok=1, the registered previous rx_ok=0, and rx_en=1; it pushes {parity_error, rxd_out}.
REQ-031 FIFO SHALL be show-ahead: rdata/rdata_perr reflect the head entry combinationally; when empty, rdata=8'hFF and rdata_perr=0.
REQ-032 pop while empty SHALL be ignored, with no state change.
REQ-033 On push without pop: if not full, count+1; if full, the byte is dropped, FIFO is unchanged, and overrun=1 next cycle.
REQ-034 On push and pop in the same cycle with count>0: both SHALL succeed, count is unchanged, and no overrun occurs, including when full.
REQ-035 On push and pop in the same cycle when empty: the pop is ignored and the push succeeds.
REQ-036 Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-037 ovr_clr SHALL clear overrun next cycle; a same-cycle overrun event SHALL win (overrun stays 1).
REQ-038 irq SHALL be registered, and irq = (!empty | overrun) of the previous cycle's state.
REQ-039 cfg_en falling SHALL NOT flush the FIFO; captures stop once rx_en=0, and any partial frame is lost.

Reset
REQ-040 While rst_n=0 at a clk edge, the following SHALL be forced: rx_en=0, tick counter=0, rx_data_sample=0, shadow div=0, no_parity=1, ev_parity=0, pointers=0, count=0, empty=1, full=0, overrun=0, irq=0, registered previous rx_ok=0.
REQ-041 Reset SHALL take priority over all other inputs, including mid-frame and mid-pop.

Verification
REQ-042 cfg_div=3, cfg_en 0->1 -> rx_en=1 after 1 clk; rx_data_sample pulses every 4 clks; cfg_div changed to 9 while enabled -> period remains 4.
REQ-043 rx_ok pulse held for 20 clks with rxd_out=8'hA5, parity_error=0 -> exactly one push; count=1; rdata=8'hA5; irq=1 one cycle after empty=0.
REQ-044 Five captures with depth 4 and no pops -> full=1, count=4, overrun=1, FIFO holds the first four bytes; ovr_clr -> overrun=0.
REQ-045 full FIFO, capture and pop in the same cycle -> count stays 4, the head advances, the new byte lands at the tail, overrun stays 0.
REQ-046 pop when empty -> rdata=8'hFF, count=0, no pointer movement; rst_n=0 mid-capture -> all outputs at reset values on the next edge.
